inst_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the opcode decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched 32-bit instruction to the decoder, then computes the next PC when the downstream stage commits.
- Next PC is selected from the decoder's PC_s, imm, address outputs and the rs register value.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_if.sv | 12 +
 rtl/inst_fetch_next_pc.sv | 36 +++
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage and the decoder.
// Holds next-PC select codes and the fetch FSM state type.
// No logic; imported by the fetch RTL.
package ifetch_pkg;

  // Next-PC select codes driven by the decoder
  localparam logic [1:0] PC_S_SEQ = 2'b00;
  localparam logic [1:0] PC_S_JR  = 2'b01;
  localparam logic [1:0] PC_S_BR  = 2'b10;
  localparam logic [1:0] PC_S_J   = 2'b11;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10,
    ERR  = 2'b11
  } ifetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory req/ack handshake between fetch stage and imem.
// Latency: set by the memory; data is valid in the cycle imem_ack is high.
// Backpressure: the fetch stage keeps imem_req high until imem_ack arrives.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_next_pc.sv
// Next-PC calculation: sequential, register jump, relative branch, absolute jump.
// Latency: purely combinational.
// Backpressure: none; all arithmetic wraps modulo 2^32.
module inst_fetch_next_pc
  import ifetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_s,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_address,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;

  assign w_pc_plus4 = i_pc + 32'd4;
  // Word offset sign-extended and scaled to bytes
  assign w_br_off   = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign o_pc_plus4 = w_pc_plus4;

  // Select the target for the decoder's PC_s code
  always_comb begin
    o_next_pc = w_pc_plus4;
    case (i_pc_s)
      PC_S_SEQ: o_next_pc = w_pc_plus4;
      PC_S_JR:  o_next_pc = i_jr_target;
      PC_S_BR:  o_next_pc = w_pc_plus4 + w_br_off;
      PC_S_J:   o_next_pc = {w_pc_plus4[31:28], i_address, 2'b00};
      default:  o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: holds PC, fetches one word per instruction, presents it to the decoder until commit.
// Latency: inst_valid the edge after imem_ack; new request the edge after commit (>= 2 cycles/inst).
// Backpressure: instruction held until commit; IFETCH_ALIGN_CHECK_EN turns misaligned targets into a sticky error.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         PC_s,
  input  logic [15:0]        imm,
  input  logic [25:0]        address,
  input  logic [31:0]        jr_target,
  input  logic               commit,
  inst_fetch_if.master       imem,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_err
);

  ifetch_state_t r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic          r_inst_valid;
  logic          r_req;
  logic          r_err;
  logic [15:0]   r_cnt;

  logic [31:0]   w_next_pc;
  logic [31:0]   w_pc_plus4;
  logic [15:0]   w_cnt_inc;

  inst_fetch_next_pc u_next_pc (
    .i_pc        (r_pc),
    .i_pc_s      (PC_s),
    .i_imm       (imm),
    .i_address   (address),
    .i_jr_target (jr_target),
    .o_pc_plus4  (w_pc_plus4),
    .o_next_pc   (w_next_pc)
  );

  assign w_cnt_inc = r_cnt + 16'd1;

  // Fetch FSM; all outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_req        <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= WAIT;
          r_req   <= 1'b1;
        end
        WAIT: begin
          if (imem.imem_ack) begin
            // ack takes priority over a timeout in the same cycle
            r_inst       <= imem.imem_rdata;
            r_inst_valid <= 1'b1;
            r_cnt        <= 16'd0;
            r_req        <= 1'b0;
            r_state      <= HOLD;
          end else begin
            r_cnt <= w_cnt_inc;
            if ((TIMEOUT != 16'd0) && (w_cnt_inc == TIMEOUT)) begin
              r_req   <= 1'b0;
              r_err   <= 1'b1;
              r_state <= ERR;
            end
          end
        end
        HOLD: begin
          if (commit) begin
            r_inst_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_pc <= w_next_pc;
            if (w_next_pc[1:0] != 2'b00) begin
              r_err   <= 1'b1;
              r_state <= ERR;
            end else begin
              r_req   <= 1'b1;
              r_state <= WAIT;
            end
`else
            // Only jr can produce low bits; they are dropped silently
            r_pc    <= w_next_pc & 32'hFFFF_FFFC;
            r_req   <= 1'b1;
            r_state <= WAIT;
`endif
          end
        end
        ERR: begin
          r_req        <= 1'b0;
          r_inst_valid <= 1'b0;
          r_err        <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign inst           = r_inst;
  assign inst_valid     = r_inst_valid;
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign fetch_err      = r_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed test-plan cases, randomized fetch/commit traffic, timeout and reset.
// Expected PCs come from an arithmetic reference of the next-PC rules.
// Memory responses and commits are driven on the falling edge; outputs are sampled there too.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  PC_s = 2'b00;
  logic [15:0] imm = 16'd0;
  logic [25:0] address = 26'd0;
  logic [31:0] jr_target = 32'd0;
  logic        commit = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  inst_fetch_if imem_if ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_s       (PC_s),
    .imm        (imm),
    .address    (address),
    .jr_target  (jr_target),
    .commit     (commit),
    .imem       (imem_if),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;    // reference PC after the last commit
  logic [31:0] m_inst;  // reference instruction being held

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference next-PC computed straight from the select rules
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] s,
                                           input logic [15:0] im, input logic [25:0] ad,
                                           input logic [31:0] jr);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(im));
    case (s)
      2'd0:    return seq;
      2'd1:    return jr;
      2'd2:    return seq + 32'(off * 4);
      default: return (seq & 32'hF000_0000) | (32'(ad) * 32'd4);
    endcase
  endfunction

  // Wait (bounded) for a request and check it targets the reference PC
  task automatic wait_req();
    for (int i = 0; i < 6 && imem_if.imem_req !== 1'b1; i++) tick();
    chk("req_seen", {31'd0, imem_if.imem_req}, 32'd1);
    chk("req_addr", imem_if.imem_addr, m_pc);
    chk("req_pc", pc, m_pc);
  endtask

  // One fetch: ack after dly no-ack cycles, hold for hold cycles, then commit
  task automatic do_fetch(input logic [31:0] rd, input int dly, input int hold,
                          input logic [1:0] s, input logic [15:0] im,
                          input logic [25:0] ad, input logic [31:0] jr);
    logic [31:0] raw;
    wait_req();
    for (int i = 0; i < dly; i++) begin
      commit = 1'($urandom_range(0, 1));  // must be ignored outside HOLD
      tick();
      chk("wait_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    commit = 1'b0;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = rd;
    m_inst = rd;
    tick();
    imem_if.imem_ack = 1'b0;
    chk("inst", inst, m_inst);
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_if.imem_req}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      imem_if.imem_ack   = 1'($urandom_range(0, 1));  // stray acks must be ignored
      imem_if.imem_rdata = $urandom;
      tick();
      chk("hold_inst", inst, m_inst);
      chk("hold_pc", pc, m_pc);
    end
    imem_if.imem_ack = 1'b0;
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    commit = 1'b1; PC_s = s; imm = im; address = ad; jr_target = jr;
    raw = ref_next(m_pc, s, im, ad, jr);
`ifdef IFETCH_ALIGN_CHECK_EN
    m_pc = raw;
`else
    m_pc = {raw[31:2], 2'b00};
`endif
    tick();
    commit = 1'b0;
    PC_s = 2'($urandom); imm = 16'($urandom); address = 26'($urandom); jr_target = $urandom;
    chk("commit_drop_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic post_ok();
    chk("post_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("post_addr", imem_if.imem_addr, m_pc);
    chk("post_err", {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_if.imem_ack = 1'b0;
    imem_if.imem_rdata = 32'd0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    m_pc = 32'h0;

    // Directed test-plan cases
    do_fetch(32'h2008_0005, 2, 1, 2'b00, 16'h0, 26'h0, 32'h0);
    post_ok(); chk("seq_pc", m_pc, 32'h4);
    do_fetch($urandom, 0, 0, 2'b01, 16'h0, 26'h0, 32'h0000_0010);
    post_ok();
    do_fetch($urandom, 1, 0, 2'b10, 16'hFFFE, 26'h0, 32'h0);
    post_ok(); chk("br_back", pc, 32'h0000_000C);
    do_fetch($urandom, 0, 0, 2'b01, 16'h0, 26'h0, 32'h0000_0010);
    do_fetch($urandom, 3, 2, 2'b10, 16'h0003, 26'h0, 32'h0);
    post_ok(); chk("br_fwd", pc, 32'h0000_0020);
    do_fetch($urandom, 0, 0, 2'b01, 16'h0, 26'h0, 32'h1000_0040);
    do_fetch($urandom, 1, 1, 2'b11, 16'h0, 26'h000_0100, 32'h0);
    post_ok(); chk("jump", pc, 32'h1000_0400);
    do_fetch($urandom, 0, 0, 2'b01, 16'h0, 26'h0, 32'hFFFF_FFFC);
    do_fetch($urandom, 2, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    post_ok(); chk("wrap", pc, 32'h0000_0000);

    // Randomized traffic with aligned jr targets
    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom),
               16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC);
      post_ok();
    end

    // Misaligned jr target
    do_fetch($urandom, 0, 1, 2'b01, 16'h0, 26'h0, 32'h0000_0102);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h0000_0102);
    tick();
    chk("mis_noreq", {31'd0, imem_if.imem_req}, 32'd0);
`else
    post_ok();
    chk("mis_pc", pc, 32'h0000_0100);
    do_fetch($urandom, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    post_ok();
`endif

    // Timeout: reset one edge, then starve the request
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_pc = 32'h0;
    chk("rst2_err", {31'd0, fetch_err}, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    tick();
    chk("to_req", {31'd0, imem_if.imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("to_not_yet", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_noreq", {31'd0, imem_if.imem_req}, 32'd0);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_if.imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_ack_err", {31'd0, fetch_err}, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst3_err", {31'd0, fetch_err}, 32'd0);
    tick();
    wait_req();

    // Reset mid-fetch with an ack arriving during and after reset
    rst_n = 1'b0; imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    tick();
    imem_if.imem_ack = 1'b0;
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_inst", inst, 32'h0);
    do_fetch(32'hCAFE_0001, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    post_ok();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
